bcd_down_timer: RTL

//   Parametrised multi-digit BCD countdown timer, the successor to the fixed 2-digit lab counter.
//   A single push pulse starts, pauses and resumes the count; it stops at zero, or auto-reloads when the macro is set.

---
 rtl/bcd_down_timer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer with push start/pause/resume control.
// A push pulse starts, pauses and resumes the count. The count stops at zero,
// or reloads when the build defines TIMER_AUTORELOAD_EN.
// count, done and the state behind running/LEDs are all held in registers.
module bcd_down_timer #(
  parameter int unsigned         DIGITS   = 2,
  parameter logic [4*DIGITS-1:0] INIT_VAL = 'h30,
  parameter int unsigned         TICK_DIV = 1,
  parameter int unsigned         LED_W    = 16
) (
  input  logic                clk_d,
  input  logic                rst,
  input  logic                push,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                running,
  output logic                done,
  output logic [LED_W-1:0]    LEDs
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] reload_q, reload_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          done_q, done_d;
  logic [CW-1:0] load_clamped;
  logic [CW-1:0] count_dec;
  logic          count_zero;
  logic          dec_zero;

  // Clamp each loaded digit to 9 so count and reload_reg always hold valid BCD.
  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      load_clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  // BCD borrow chain from digit0. A 0 digit becomes 9 and passes the borrow on.
  always_comb begin
    logic borrow;
    borrow    = 1'b1;
    count_dec = count_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow              = 1'b0;
        end
      end
    end
  end

  assign count_zero = (count_q == '0);
  assign dec_zero   = (count_dec == '0);

  // Next state. Priority is load, then push, then prescaler tick.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    pre_d    = pre_q;
    done_d   = 1'b0;
    if (load) begin
      count_d  = load_clamped;
      reload_d = load_clamped;
      state_d  = StIdle;
      pre_d    = '0;
    end else if (push) begin
      unique case (state_q)
        StIdle: begin
          pre_d = '0;
          if (count_zero) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
        StRun:   state_d = StPause;  // prescaler held; a coinciding tick is dropped
        StPause: state_d = StRun;
        StDone: begin
          state_d = StIdle;
          count_d = reload_q;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q == StRun) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        if (dec_zero || count_zero) begin
          done_d = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
          count_d = reload_q;
`else
          count_d = '0;
          state_d = StDone;
`endif
        end else begin
          count_d = count_dec;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_d) begin
    if (!rst) begin
      state_q  <= StIdle;
      count_q  <= INIT_VAL;
      reload_q <= INIT_VAL;
      pre_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      pre_q    <= pre_d;
      done_q   <= done_d;
    end
  end

  assign count   = count_q;
  assign done    = done_q;
  assign running = (state_q == StRun);
  assign LEDs    = {LED_W{state_q == StDone}};

endmodule
